// File: rtl/hazard_ctrl.sv
// Issue/stall sequencer for the 16-bit core: RAW scoreboard, branch squash
// window and multiplier busy tracking, decided combinationally in ID.
module hazard_ctrl #(
    parameter int PIPE_DEPTH = 3,
    parameter int BR_PENALTY = 2,
    parameter int MULT_LAT   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       IdValid,
    input  logic [3:0] OpA,
    input  logic [3:0] OpB,
    input  logic [3:0] OpC,
    input  logic       IsImm,
    input  logic       HasWB,
    input  logic       HasStall,
    input  logic       IsJump,
    input  logic       IsMult,
    input  logic       StoreHiLo,
    output logic       Issue,
    output logic       StallIF,
    output logic       Bubble,
    output logic       Flush,
    output logic       MultStart,
    output logic       MultBusy
);

    localparam int BW = (BR_PENALTY > 0) ? $clog2(BR_PENALTY + 1) : 1;
    localparam int MW = (MULT_LAT > 0) ? $clog2(MULT_LAT + 1) : 1;

    typedef enum logic {
        S_RUN,
        S_BRANCH
    } state_t;

    state_t                       state_q, state_d;
    logic [BW-1:0]                br_ctr_q, br_ctr_d;
    logic [MW-1:0]                mult_ctr_q, mult_ctr_d;
    logic [PIPE_DEPTH-1:0]        sb_vld_q, sb_vld_d;
    logic [PIPE_DEPTH-1:0][3:0]   sb_dst_q, sb_dst_d;

    logic use_a;
    logic use_b;
    logic raw_haz;
    logic mult_haz;
    logic busy;

    always_comb begin
        use_a   = !IsJump && !StoreHiLo;
        use_b   = use_a && !IsImm;
        raw_haz = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_vld_q[i] &&
                ((use_a && sb_dst_q[i] == OpA) ||
                 (use_b && sb_dst_q[i] == OpB)))
                raw_haz = 1'b1;
        end
        busy     = (mult_ctr_q != '0);
        mult_haz = busy && (IsMult || StoreHiLo);
    end

    always_comb begin
        state_d  = state_q;
        br_ctr_d = br_ctr_q;
        Issue    = 1'b0;
        StallIF  = 1'b0;
        Flush    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                Issue   = IdValid && !raw_haz && !mult_haz;
                StallIF = IdValid && !Issue;
                if (Issue && HasStall && (BR_PENALTY > 0)) begin
                    state_d  = S_BRANCH;
                    br_ctr_d = BW'(BR_PENALTY);
                end
            end
            S_BRANCH: begin
                Flush    = 1'b1;
                br_ctr_d = br_ctr_q - BW'(1);
                if (br_ctr_q <= BW'(1))
                    state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        // Reset quiets every output so nothing issues while state is cleared
        if (Reset) begin
            Issue   = 1'b0;
            StallIF = 1'b0;
            Flush   = 1'b0;
        end
        Bubble    = !Issue;
        MultStart = Issue && IsMult;
        MultBusy  = busy && !Reset;

        if (MultStart)
            mult_ctr_d = MW'(MULT_LAT);
        else if (busy)
            mult_ctr_d = mult_ctr_q - MW'(1);
        else
            mult_ctr_d = '0;

        sb_vld_d    = '0;
        sb_dst_d    = '0;
        sb_vld_d[0] = Issue && HasWB;
        sb_dst_d[0] = OpC;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            sb_vld_d[i] = sb_vld_q[i-1];
            sb_dst_d[i] = sb_dst_q[i-1];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_RUN;
            br_ctr_q   <= '0;
            mult_ctr_q <= '0;
            sb_vld_q   <= '0;
            sb_dst_q   <= '0;
        end else begin
            state_q    <= state_d;
            br_ctr_q   <= br_ctr_d;
            mult_ctr_q <= mult_ctr_d;
            sb_vld_q   <= sb_vld_d;
            sb_dst_q   <= sb_dst_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table followed by
// randomized traffic against an age-based reference model.
module tb_hazard_ctrl;

    localparam int PIPE_DEPTH = 3;
    localparam int BR_PENALTY = 2;
    localparam int MULT_LAT   = 4;

    logic       Clock = 1'b0;
    logic       Reset, IdValid, IsImm, HasWB, HasStall, IsJump, IsMult, StoreHiLo;
    logic [3:0] OpA, OpB, OpC;
    logic       Issue, StallIF, Bubble, Flush, MultStart, MultBusy;

    always #5 Clock = ~Clock;

    hazard_ctrl #(
        .PIPE_DEPTH(PIPE_DEPTH),
        .BR_PENALTY(BR_PENALTY),
        .MULT_LAT  (MULT_LAT)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .IdValid  (IdValid),
        .OpA      (OpA),
        .OpB      (OpB),
        .OpC      (OpC),
        .IsImm    (IsImm),
        .HasWB    (HasWB),
        .HasStall (HasStall),
        .IsJump   (IsJump),
        .IsMult   (IsMult),
        .StoreHiLo(StoreHiLo),
        .Issue    (Issue),
        .StallIF  (StallIF),
        .Bubble   (Bubble),
        .Flush    (Flush),
        .MultStart(MultStart),
        .MultBusy (MultBusy)
    );

    // exp = {Issue, StallIF, Bubble, Flush, MultStart, MultBusy}
    typedef struct {
        logic       rst, vld;
        logic [3:0] a, b, c;
        logic       imm, wb, hs, jmp, mul, hilo;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] dst;
    } wr_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    wr_t  hist[$];
    int   now      = 0;
    int   mult_cyc = -100;
    int   br_cyc   = -100;

    function automatic vec_t mk(
        logic rst, logic vld, logic [3:0] a, logic [3:0] b, logic [3:0] c,
        logic imm, logic wb, logic hs, logic jmp, logic mul, logic hilo,
        logic iss, logic stl, logic fl, logic ms, logic mb);
        vec_t v;
        v.rst = rst; v.vld = vld; v.a = a; v.b = b; v.c = c;
        v.imm = imm; v.wb = wb; v.hs = hs; v.jmp = jmp;
        v.mul = mul; v.hilo = hilo;
        v.exp = {iss, stl, !iss, fl, ms, mb};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Reset = v.rst; IdValid = v.vld;
        OpA = v.a; OpB = v.b; OpC = v.c;
        IsImm = v.imm; HasWB = v.wb; HasStall = v.hs;
        IsJump = v.jmp; IsMult = v.mul; StoreHiLo = v.hilo;
    endtask

    task automatic check(input string nm, input int idx, input logic [5:0] exp);
        logic [5:0] got;
        got = {Issue, StallIF, Bubble, Flush, MultStart, MultBusy};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got(iss,stl,bub,fl,ms,mb)=%b expected=%b",
                     nm, idx, got, exp);
        end
    endtask

    // Reference: hazards judged by how many cycles ago each event issued
    function automatic logic [5:0] model(input vec_t v);
        logic mb, br, ua, ub, raw, iss;
        int   age;
        if (v.rst) return 6'b001000;
        mb = (now - mult_cyc >= 1) && (now - mult_cyc <= MULT_LAT);
        br = (now - br_cyc >= 1) && (now - br_cyc <= BR_PENALTY);
        if (br) return {4'b0011, 1'b0, mb};
        ua  = !v.jmp && !v.hilo;
        ub  = ua && !v.imm;
        raw = 1'b0;
        foreach (hist[i]) begin
            age = now - hist[i].cyc;
            if (age >= 1 && age <= PIPE_DEPTH &&
                ((ua && hist[i].dst == v.a) || (ub && hist[i].dst == v.b)))
                raw = 1'b1;
        end
        iss = v.vld && !raw && !(mb && (v.mul || v.hilo));
        return {iss, v.vld && !iss, !iss, 1'b0, iss && v.mul, mb};
    endfunction

    task automatic model_update(input vec_t v, input logic iss);
        wr_t w;
        if (v.rst) begin
            hist.delete();
            mult_cyc = -100;
            br_cyc   = -100;
        end else if (iss) begin
            if (v.wb) begin
                w.cyc = now; w.dst = v.c;
                hist.push_back(w);
            end
            if (v.mul) mult_cyc = now;
            if (v.hs)  br_cyc   = now;
        end
        now++;
        while (hist.size() > 0 && now - hist[0].cyc > PIPE_DEPTH)
            void'(hist.pop_front());
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.rst  = ($urandom_range(0, 63) == 0);
        v.vld  = ($urandom_range(0, 3) != 0);
        v.a    = 4'($urandom_range(0, 3));
        v.b    = 4'($urandom_range(0, 3));
        v.c    = 4'($urandom_range(0, 3));
        v.imm  = ($urandom_range(0, 3) == 0);
        v.wb   = 1'($urandom_range(0, 1));
        v.hs   = ($urandom_range(0, 7) == 0);
        v.jmp  = v.hs && 1'($urandom_range(0, 1));
        v.mul  = ($urandom_range(0, 9) == 0);
        v.hilo = ($urandom_range(0, 9) == 0);
        v.exp  = '0;
        return v;
    endfunction

    initial begin
        vec_t       v;
        logic [5:0] e;

        drive(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));

        // reset held with ADD pending, then ADD issues
        tbl.push_back(mk(1,1,1,2,3,0,1,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,1,2,3,0,1,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,2,3,0,1,0,0,0,0, 1,0,0,0,0));
        // SUB r4,r3,r5 waits out the scoreboard
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,3,5,4,0,1,0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,1,3,5,4,0,1,0,0,0,0, 1,0,0,0,0));
        // ADD r3 then ADDI r6 with imm=3
        tbl.push_back(mk(0,1,1,2,3,0,1,0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,3,6,1,1,0,0,0,0, 1,0,0,0,0));
        // BEZ then two flush cycles
        tbl.push_back(mk(0,1,1,2,0,0,0,1,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,1,9,10,8,0,1,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,1,9,10,8,0,1,0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,1,9,10,8,0,1,0,0,0,0, 1,0,0,0,0));
        // MUL then GLO r7 stalls for the busy window
        tbl.push_back(mk(0,1,1,2,0,0,0,0,0,1,0, 1,0,0,1,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,1,0,0,7,0,1,0,0,0,1, 0,1,0,0,1));
        tbl.push_back(mk(0,1,0,0,7,0,1,0,0,0,1, 1,0,0,0,0));
        // reset inside BRANCH with ctr=1 and multiplier busy
        tbl.push_back(mk(0,1,1,2,0,0,0,0,0,1,0, 1,0,0,1,0));
        tbl.push_back(mk(0,1,1,2,5,0,1,1,0,0,0, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,5,2,6,0,1,0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,2,0,0,0,0,0,1,0, 1,0,0,1,0));
        // J ignores its register fields even when they match the scoreboard
        tbl.push_back(mk(0,1,6,6,0,0,0,1,1,0,0, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clock);
            drive(tbl[i]);
            #1;
            check("directed", i, tbl[i].exp);
        end

        for (int k = 0; k < 3000; k++) begin
            v = rand_vec();
            if (k < 2) v.rst = 1'b1;
            @(negedge Clock);
            drive(v);
            #1;
            e = model(v);
            check("random", k, e);
            model_update(v, e[5]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
